// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//
// APB completer holding NUM_REGS read/write registers and a read-only transfer
// counter. Each transfer is accepted from a setup phase, held for WAIT_CYCLES
// access cycles with pready low, and then answered with a single-cycle pready
// pulse. All outputs are registered.
//
// Ports
//   clk      in   1           rising-edge clock
//   reset    in   1           synchronous, active-high reset
//   psel     in   1           APB select
//   penable  in   1           APB enable (access phase)
//   pwrite   in   1           1 = write, 0 = read
//   paddr    in   ADDR_WIDTH  APB address
//   pwdata   in   DATA_WIDTH  APB write data
//   prdata   out  DATA_WIDTH  read data, non-zero only while pready=1
//   pready   out  1           transfer complete, one cycle per transfer
//   pslverr  out  1           error response, only while pready=1
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter int ADDR_WIDTH                   = 8,
    parameter int DATA_WIDTH                   = 8,
    parameter int NUM_REGS                     = 16,
    parameter int WAIT_CYCLES                  = 1,
    parameter logic [ADDR_WIDTH-1:0] CNT_ADDR  = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int                  IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0]          WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] ZERO_D   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_D    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t                 state_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic                   write_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic [3:0]             wait_r;
    logic [DATA_WIDTH-1:0]  regs_r [NUM_REGS];
    logic [DATA_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH-1:0]  prdata_r;
    logic                   pready_r;
    logic                   pslverr_r;

    logic                   setup_s;
    logic                   commit_s;
    logic [ADDR_WIDTH-1:0]  dec_addr_s;
    logic                   dec_write_s;
    logic [DATA_WIDTH-1:0]  dec_wdata_s;
    logic [IDX_W-1:0]       dec_idx_s;
    logic                   hit_reg_s;
    logic                   hit_cnt_s;
    logic                   wr_en_s;
    logic [DATA_WIDTH-1:0]  rd_data_s;
    logic                   err_s;

    assign setup_s   = psel & ~penable;
    assign prdata    = prdata_r;
    assign pready    = pready_r;
    assign pslverr   = pslverr_r;

    // Decide whether this edge enters RESP, and pick the transfer fields to decode.
    // With zero wait states the commit happens on the setup edge itself, so the
    // live bus values are used because the latches are only being loaded now.
    always_comb begin
        commit_s    = 1'b0;
        dec_addr_s  = addr_r;
        dec_write_s = write_r;
        dec_wdata_s = wdata_r;
        case (state_r)
            IDLE: begin
                if (setup_s && (WAIT_INIT == 4'd0)) begin
                    commit_s    = 1'b1;
                    dec_addr_s  = paddr;
                    dec_write_s = pwrite;
                    dec_wdata_s = pwdata;
                end else begin
                    commit_s    = 1'b0;
                end
            end
            ACCESS: begin
                if (psel && penable && (wait_r == 4'd1)) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            RESP: begin
                commit_s = 1'b0;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Address decode and response data for the transfer being committed.
    always_comb begin
        dec_idx_s = dec_addr_s[IDX_W-1:0];
        hit_reg_s = ({1'b0, dec_addr_s} < NUM_REGS_W);
        hit_cnt_s = (dec_addr_s == CNT_ADDR);
        wr_en_s   = 1'b0;
        rd_data_s = ZERO_D;
        err_s     = 1'b0;
        if (hit_reg_s) begin
            wr_en_s   = commit_s & dec_write_s;
            rd_data_s = dec_write_s ? ZERO_D : regs_r[dec_idx_s];
            err_s     = 1'b0;
        end else if (hit_cnt_s) begin
            // Counter is read-only; the pre-increment value is returned.
            wr_en_s   = 1'b0;
            rd_data_s = dec_write_s ? ZERO_D : cnt_r;
            err_s     = dec_write_s;
        end else begin
            wr_en_s   = 1'b0;
            rd_data_s = ZERO_D;
            err_s     = 1'b1;
        end
    end

    // Transfer FSM: latches the setup phase, counts wait states, drives the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            write_r   <= 1'b0;
            wdata_r   <= ZERO_D;
            wait_r    <= 4'd0;
            prdata_r  <= ZERO_D;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    prdata_r  <= ZERO_D;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    if (setup_s) begin
                        addr_r  <= paddr;
                        write_r <= pwrite;
                        wdata_r <= pwdata;
                        wait_r  <= WAIT_INIT;
                        if (commit_s) begin
                            state_r   <= RESP;
                            prdata_r  <= rd_data_s;
                            pready_r  <= 1'b1;
                            pslverr_r <= err_s;
                        end else begin
                            state_r <= ACCESS;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Master abandoned the transfer: no response, no commit.
                        state_r <= IDLE;
                        wait_r  <= 4'd0;
                    end else if (commit_s) begin
                        state_r   <= RESP;
                        wait_r    <= 4'd0;
                        prdata_r  <= rd_data_s;
                        pready_r  <= 1'b1;
                        pslverr_r <= err_s;
                    end else if (penable) begin
                        wait_r <= wait_r - 4'd1;
                    end else begin
                        wait_r <= wait_r;
                    end
                end
                RESP: begin
                    state_r   <= IDLE;
                    prdata_r  <= ZERO_D;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    prdata_r  <= ZERO_D;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    // Register bank and transfer counter, updated only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= ZERO_D;
            end
            cnt_r <= ZERO_D;
        end else if (commit_s) begin
            cnt_r <= cnt_r + ONE_D;
            if (wr_en_s) begin
                regs_r[dec_idx_s] <= dec_wdata_s;
            end
        end
    end

endmodule
